// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Purpose:
//   Sits between the CPU and a word-organised data memory. It accepts one
//   byte, half or word load/store at a time. It turns each request into
//   word-aligned memory strobes and returns a one-cycle completion pulse.
//   Sub-word stores are done as read-modify-write: the word is read, the
//   target lanes are merged in, and the word is written back. Misaligned,
//   illegal-size and out-of-range requests complete with resp_err and touch
//   no memory.
//
// Parameters:
//   MEM_BYTES     byte capacity of the attached memory; addresses at or above
//                 this value are rejected as errors.
//
// Ports:
//   clk           single clock, rising-edge active
//   reset         asynchronous active-low reset
//   req_valid     CPU request present
//   req_ready     unit idle and able to accept a request
//   req_write     1 = store, 0 = load
//   req_size      00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned  1 = zero-extend load data, 0 = sign-extend
//   req_addr      byte address
//   req_wdata     store data, right-aligned
//   resp_valid    one-cycle completion pulse
//   resp_rdata    extended load data (0 for stores and errors)
//   resp_err      request was rejected (valid with resp_valid)
//   mem_addr      word-aligned memory address
//   mem_din       merged write word (0 outside the write cycle)
//   mem_read      read strobe; mem_dout is valid combinationally this cycle
//   mem_write     write strobe; memory commits mem_din on the rising edge
//   mem_dout      read data from memory
// -----------------------------------------------------------------------------
module load_store_unit #(
   parameter int MEM_BYTES = 65536
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_din,
   output logic        mem_read,
   output logic        mem_write,
   input  logic [31:0] mem_dout
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RD   = 2'd1;
   localparam logic [1:0] S_WR   = 2'd2;
   localparam logic [1:0] S_RESP = 2'd3;

   // Extended by one bit so a capacity of 2^32 would still compare correctly.
   localparam logic [32:0] LP_LIMIT = 33'(MEM_BYTES);

   logic [1:0]  r_state;
   logic [1:0]  w_next;
   logic        w_accept;
   logic        w_err;

   logic [31:0] r_addr;
   logic [1:0]  r_size;
   logic        r_unsigned;
   logic        r_write;
   logic        r_err;
   logic [31:0] r_wdata;
   logic [31:0] r_rword;

   // Pick the addressed byte/half out of a memory word and extend it.
   function automatic logic [31:0] f_extract(input logic [31:0] word,
                                             input logic [1:0]  size,
                                             input logic        uns,
                                             input logic [1:0]  lane);
      logic [7:0]  b;
      logic [15:0] h;
      case (lane)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      h = lane[1] ? word[31:16] : word[15:0];
      case (size)
         2'b00:   return {{24{~uns & b[7]}}, b};
         2'b01:   return {{16{~uns & h[15]}}, h};
         default: return word;
      endcase
   endfunction

   // Overlay the right-aligned store data onto the lanes it targets.
   function automatic logic [31:0] f_merge(input logic [31:0] word,
                                           input logic [31:0] wdata,
                                           input logic [1:0]  size,
                                           input logic [1:0]  lane);
      logic [31:0] m;
      m = word;
      case (size)
         2'b00: begin
            case (lane)
               2'd0:    m[7:0]   = wdata[7:0];
               2'd1:    m[15:8]  = wdata[7:0];
               2'd2:    m[23:16] = wdata[7:0];
               default: m[31:24] = wdata[7:0];
            endcase
         end
         2'b01: begin
            if (lane[1]) m[31:16] = wdata[15:0];
            else         m[15:0]  = wdata[15:0];
         end
         default: m = wdata;
      endcase
      return m;
   endfunction

   // req_ready is gated by reset so every output reads 0 while it is held.
   assign req_ready = reset & (r_state == S_IDLE);
   assign w_accept  = req_valid & req_ready;

   assign w_err = (req_size == 2'b11)
                | ((req_size == 2'b01) & req_addr[0])
                | ((req_size == 2'b10) & (req_addr[1:0] != 2'b00))
                | ({1'b0, req_addr} >= LP_LIMIT);

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (w_err)                  w_next = S_RESP;
               else if (!req_write)        w_next = S_RD;
               else if (req_size == 2'b10) w_next = S_WR;
               else                        w_next = S_RD;  // read-modify-write
            end
         end
         S_RD:    w_next = r_write ? S_WR : S_RESP;
         S_WR:    w_next = S_RESP;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Request fields and read word need no reset: every output that uses them
   // is qualified by the state, which reset forces to IDLE.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_addr     <= req_addr;
         r_size     <= req_size;
         r_unsigned <= req_unsigned;
         r_write    <= req_write;
         r_err      <= w_err;
         r_wdata    <= req_wdata;
      end
      if (r_state == S_RD) r_rword <= mem_dout;
   end

   assign mem_read   = (r_state == S_RD);
   assign mem_write  = (r_state == S_WR);
   assign mem_addr   = (r_state != S_IDLE) ? {r_addr[31:2], 2'b00} : 32'd0;
   assign mem_din    = mem_write ? f_merge(r_rword, r_wdata, r_size, r_addr[1:0]) : 32'd0;

   assign resp_valid = (r_state == S_RESP);
   assign resp_err   = resp_valid & r_err;
   assign resp_rdata = (resp_valid & ~r_write & ~r_err)
                     ? f_extract(r_rword, r_size, r_unsigned, r_addr[1:0]) : 32'd0;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] mem_addr;
   logic [31:0] mem_din;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_dout;

   logic [31:0] mem  [0:16383];   // memory attached to the DUT
   logic [31:0] smem [0:16383];   // reference model's view of memory

   int total = 0;
   int bad   = 0;

   load_store_unit #(.MEM_BYTES(65536)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_err(resp_err), .mem_addr(mem_addr), .mem_din(mem_din),
      .mem_read(mem_read), .mem_write(mem_write), .mem_dout(mem_dout)
   );

   always #5 clk = ~clk;

   assign mem_dout = mem[mem_addr[15:2]];
   always @(posedge clk) if (mem_write) mem[mem_addr[15:2]] = mem_din;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Reference model: works from the request rules directly on a word array.
   task automatic model(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rdata, output logic err,
                        output int nrd, output int nwr, output logic [31:0] din);
      logic [31:0] word, mask, val;
      int sh;
      err = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0)
            || (a >= 32'd65536);
      rdata = 0; din = 0; nrd = 0; nwr = 0; lat = 1;
      if (!err) begin
         word = smem[a / 4];
         sh   = (sz == 2'd0) ? 8 * int'(a % 4) : (sz == 2'd1) ? 16 * int'((a / 2) % 2) : 0;
         mask = (sz == 2'd0) ? 32'hFF : (sz == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
         if (!w) begin
            val = (word >> sh) & mask;
            if (!u && sz == 2'd0 && val >= 32'h80)   val = val + 32'hFFFF_FF00;
            if (!u && sz == 2'd1 && val >= 32'h8000) val = val + 32'hFFFF_0000;
            rdata = val; lat = 2; nrd = 1;
         end else begin
            din = (word & ~(mask << sh)) | ((wd & mask) << sh);
            smem[a / 4] = din;
            lat = (sz == 2'd2) ? 2 : 3;
            nrd = (sz == 2'd2) ? 0 : 1;
            nwr = 1;
         end
      end
   endtask

   task automatic preload(input int idx, input logic [31:0] v);
      mem[idx]  = v;
      smem[idx] = v;
   endtask

   // Issue one request and observe it to completion (bounded).
   task automatic drive_req(input logic w, input logic [1:0] sz, input logic u,
                            input logic [31:0] a, input logic [31:0] wd,
                            output int lat, output logic [31:0] rdata, output logic err,
                            output int nrd, output int nwr, output logic [31:0] din,
                            output int viol);
      @(negedge clk);
      for (int k = 0; k < 20 && !req_ready; k++) @(negedge clk);
      req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 0; nrd = 0; nwr = 0; viol = 0; din = 0; rdata = 0; err = 0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (mem_read) nrd++;
         if (mem_write) begin nwr++; din = mem_din; end
         else if (mem_din !== 32'd0) viol++;
         if (mem_read && mem_write) viol++;
         if (mem_addr !== {a[31:2], 2'b00}) viol++;
         if (resp_valid) begin lat = c; rdata = resp_rdata; err = resp_err; break; end
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2;
      req_unsigned = 1'b0; req_addr = 32'h10; req_wdata = 32'h0;
      repeat (3) @(negedge clk);
      total++; if (req_ready  !== 1'b0) begin bad++; $display("FAIL rst_ready got=%0b want=0", req_ready); end
      total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rst_resp_valid got=%0b want=0", resp_valid); end
      total++; if (resp_rdata !== 32'd0) begin bad++; $display("FAIL rst_rdata got=%h want=0", resp_rdata); end
      total++; if (resp_err   !== 1'b0) begin bad++; $display("FAIL rst_err got=%0b want=0", resp_err); end
      total++; if (mem_addr   !== 32'd0) begin bad++; $display("FAIL rst_mem_addr got=%h want=0", mem_addr); end
      total++; if (mem_din    !== 32'd0) begin bad++; $display("FAIL rst_mem_din got=%h want=0", mem_din); end
      total++; if (mem_read   !== 1'b0) begin bad++; $display("FAIL rst_mem_read got=%0b want=0", mem_read); end
      total++; if (mem_write  !== 1'b0) begin bad++; $display("FAIL rst_mem_write got=%0b want=0", mem_write); end
      req_valid = 1'b0;
      reset = 1'b1;
      #1;
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%0b want=1", req_ready); end
   endtask

   task automatic test_load_byte();
      int lat, nrd, nwr, viol; logic [31:0] rd, din; logic err;
      preload(32'h10 / 4, 32'h8899AABB);
      drive_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, lat, rd, err, nrd, nwr, din, viol);
      total++; if (lat !== 2) begin bad++; $display("FAIL ldb_s_lat got=%0d want=2", lat); end
      total++; if (rd !== 32'hFFFFFF88) begin bad++; $display("FAIL ldb_s_rdata got=%h want=ffffff88", rd); end
      total++; if (nrd !== 1 || nwr !== 0 || err !== 1'b0 || viol !== 0)
         begin bad++; $display("FAIL ldb_s_strobes got rd=%0d wr=%0d err=%0b viol=%0d want 1 0 0 0", nrd, nwr, err, viol); end
      drive_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, lat, rd, err, nrd, nwr, din, viol);
      total++; if (rd !== 32'h00000088) begin bad++; $display("FAIL ldb_u_rdata got=%h want=00000088", rd); end
      total++; if (lat !== 2) begin bad++; $display("FAIL ldb_u_lat got=%0d want=2", lat); end
   endtask

   task automatic test_store_half();
      int lat, nrd, nwr, viol; logic [31:0] rd, din; logic err;
      preload(32'h20 / 4, 32'h11223344);
      drive_req(1'b1, 2'd1, 1'b0, 32'h22, 32'h0000BEEF, lat, rd, err, nrd, nwr, din, viol);
      smem[32'h20 / 4] = 32'hBEEF3344;
      total++; if (lat !== 3) begin bad++; $display("FAIL sth_lat got=%0d want=3", lat); end
      total++; if (din !== 32'hBEEF3344) begin bad++; $display("FAIL sth_din got=%h want=beef3344", din); end
      total++; if (nrd !== 1 || nwr !== 1 || err !== 1'b0 || rd !== 32'd0 || viol !== 0)
         begin bad++; $display("FAIL sth_strobes got rd=%0d wr=%0d err=%0b rdata=%h viol=%0d want 1 1 0 0 0", nrd, nwr, err, rd, viol); end
      total++; if (mem[32'h20 / 4] !== 32'hBEEF3344) begin bad++; $display("FAIL sth_mem got=%h want=beef3344", mem[32'h20 / 4]); end
   endtask

   task automatic test_store_word();
      int lat, nrd, nwr, viol; logic [31:0] rd, din; logic err;
      drive_req(1'b1, 2'd2, 1'b0, 32'h04, 32'hDEADBEEF, lat, rd, err, nrd, nwr, din, viol);
      smem[1] = 32'hDEADBEEF;
      total++; if (lat !== 2) begin bad++; $display("FAIL stw_lat got=%0d want=2", lat); end
      total++; if (din !== 32'hDEADBEEF) begin bad++; $display("FAIL stw_din got=%h want=deadbeef", din); end
      total++; if (nrd !== 0 || nwr !== 1 || err !== 1'b0 || viol !== 0)
         begin bad++; $display("FAIL stw_strobes got rd=%0d wr=%0d err=%0b viol=%0d want 0 1 0 0", nrd, nwr, err, viol); end
      total++; if (mem[1] !== 32'hDEADBEEF) begin bad++; $display("FAIL stw_mem got=%h want=deadbeef", mem[1]); end
   endtask

   task automatic test_errors();
      int lat, nrd, nwr, viol; logic [31:0] rd, din; logic err;
      logic [1:0]  sz [4] = '{2'd2, 2'd1, 2'd3, 2'd2};
      logic [31:0] ad [4] = '{32'h06, 32'h01, 32'h08, 32'h10000};
      for (int i = 0; i < 4; i++) begin
         drive_req(1'b0, sz[i], 1'b0, ad[i], 32'h0, lat, rd, err, nrd, nwr, din, viol);
         total++; if (err !== 1'b1 || lat !== 1)
            begin bad++; $display("FAIL err_case%0d got err=%0b lat=%0d want err=1 lat=1", i, err, lat); end
         total++; if (nrd !== 0 || nwr !== 0 || rd !== 32'd0 || viol !== 0)
            begin bad++; $display("FAIL err_case%0d_strobes got rd=%0d wr=%0d rdata=%h viol=%0d want 0 0 0 0", i, nrd, nwr, rd, viol); end
      end
      // a store that errors must not write either
      drive_req(1'b1, 2'd1, 1'b0, 32'h21, 32'h1234, lat, rd, err, nrd, nwr, din, viol);
      total++; if (err !== 1'b1 || nwr !== 0 || nrd !== 0)
         begin bad++; $display("FAIL err_store got err=%0b rd=%0d wr=%0d want 1 0 0", err, nrd, nwr); end
   endtask

   task automatic test_random();
      int lat, nrd, nwr, viol, elat, enrd, enwr; logic [31:0] rd, din, erd, edin, a, wd;
      logic err, eerr, w, u; logic [1:0] sz;
      for (int i = 0; i < 60; i++) begin
         w = 1'($urandom_range(0, 1)); u = 1'($urandom_range(0, 1));
         sz = 2'($urandom_range(0, 3)); wd = $urandom;
         case ($urandom_range(0, 7))
            0:       a = 32'h10000 + $urandom_range(0, 15);
            1:       a = 32'hFFFC + $urandom_range(0, 3);
            default: a = $urandom_range(0, 255);
         endcase
         model(w, sz, u, a, wd, elat, erd, eerr, enrd, enwr, edin);
         drive_req(w, sz, u, a, wd, lat, rd, err, nrd, nwr, din, viol);
         total++; if (lat !== elat || err !== eerr)
            begin bad++; $display("FAIL rnd%0d_lat_err a=%h sz=%0d w=%0b got lat=%0d err=%0b want lat=%0d err=%0b", i, a, sz, w, lat, err, elat, eerr); end
         total++; if (rd !== erd)
            begin bad++; $display("FAIL rnd%0d_rdata a=%h sz=%0d u=%0b got=%h want=%h", i, a, sz, u, rd, erd); end
         total++; if (nrd !== enrd || nwr !== enwr || viol !== 0)
            begin bad++; $display("FAIL rnd%0d_strobes got rd=%0d wr=%0d viol=%0d want rd=%0d wr=%0d viol=0", i, nrd, nwr, viol, enrd, enwr); end
         if (enwr == 1) begin
            total++; if (din !== edin || mem[a[15:2]] !== smem[a[15:2]])
               begin bad++; $display("FAIL rnd%0d_write a=%h got din=%h mem=%h want %h", i, a, din, mem[a[15:2]], edin); end
         end
      end
   endtask

   task automatic test_abort();
      int nwr = 0, nresp = 0;
      preload(32'h30 / 4, 32'hCAFEF00D);
      @(negedge clk);
      req_write = 1'b1; req_size = 2'd0; req_unsigned = 1'b0; req_addr = 32'h31;
      req_wdata = 32'h000000A5; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      total++; if (mem_read !== 1'b1) begin bad++; $display("FAIL abort_in_rd got mem_read=%0b want=1", mem_read); end
      reset = 1'b0;
      #1;
      total++; if (mem_read !== 1'b0 || mem_addr !== 32'd0 || req_ready !== 1'b0)
         begin bad++; $display("FAIL abort_outputs got rd=%0b addr=%h ready=%0b want 0 0 0", mem_read, mem_addr, req_ready); end
      @(negedge clk); @(negedge clk);
      reset = 1'b1;
      #1;
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL abort_ready got=%0b want=1", req_ready); end
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (mem_write)  nwr++;
         if (resp_valid) nresp++;
      end
      total++; if (nwr !== 0 || nresp !== 0)
         begin bad++; $display("FAIL abort_quiet got writes=%0d resps=%0d want 0 0", nwr, nresp); end
      total++; if (mem[32'h30 / 4] !== 32'hCAFEF00D)
         begin bad++; $display("FAIL abort_mem got=%h want=cafef00d", mem[32'h30 / 4]); end
   endtask

   task automatic test_back_to_back();
      int free_at = 0, resp_at = -1, lat, nrd, nwr;
      logic [31:0] erd, edin, a, wd; logic eerr, w, u, exp_ready; logic [1:0] sz;
      for (int n = 0; n < 70; n++) begin
         @(negedge clk);
         exp_ready = (n >= free_at);
         total++; if (req_ready !== exp_ready)
            begin bad++; $display("FAIL b2b_ready cyc=%0d got=%0b want=%0b", n, req_ready, exp_ready); end
         total++; if (resp_valid !== (n == resp_at))
            begin bad++; $display("FAIL b2b_resp_valid cyc=%0d got=%0b want=%0b", n, resp_valid, (n == resp_at)); end
         if (n == resp_at) begin
            total++; if (resp_rdata !== erd || resp_err !== eerr)
               begin bad++; $display("FAIL b2b_resp cyc=%0d got rdata=%h err=%0b want rdata=%h err=%0b", n, resp_rdata, resp_err, erd, eerr); end
         end
         w = 1'($urandom_range(0, 1)); u = 1'($urandom_range(0, 1));
         sz = 2'($urandom_range(0, 3)); wd = $urandom;
         a = ($urandom_range(0, 9) == 0) ? 32'h10000 : $urandom_range(0, 127);
         req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
         req_valid = (n < 60);
         if (n < 60 && exp_ready) begin
            model(w, sz, u, a, wd, lat, erd, eerr, nrd, nwr, edin);
            resp_at = n + lat;
            free_at = n + lat + 1;
         end
      end
      req_valid = 1'b0;
      for (int i = 0; i < 32; i++) begin
         total++; if (mem[i] !== smem[i])
            begin bad++; $display("FAIL b2b_mem word=%0d got=%h want=%h", i, mem[i], smem[i]); end
      end
   endtask

   initial begin
      for (int i = 0; i < 16384; i++) preload(i, (i < 128 || i > 16300) ? $urandom : 32'd0);
      test_reset();
      test_load_byte();
      test_store_half();
      test_store_word();
      test_errors();
      test_random();
      test_abort();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: MEM_BYTES, default 65536, byte capacity of the attached data memory; requests with req_addr >= MEM_BYTES SHALL be errors.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  CPU request present.
REQ-005 req_ready  output  1  unit accepts a request this cycle; SHALL be 1 only in IDLE.
REQ-006 req_write  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-008 req_unsigned  input  1  1 = zero-extend load data, 0 = sign-extend.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, right-aligned.
REQ-011 resp_valid  output  1  one-cycle completion pulse.
REQ-012 resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-013 resp_err  output  1  misaligned, illegal-size or out-of-range request; valid with resp_valid.
REQ-014 mem_addr  output  32  word-aligned address to data memory, bits [1:0] always 00.
REQ-015 mem_din  output  32  write data to data memory.
REQ-016 mem_read  output  1  read strobe; memory returns mem_dout combinationally in the same cycle.
REQ-017 mem_write  output  1  write strobe; memory commits mem_din at the rising edge.
REQ-018 mem_dout  input  32  read data from data memory.

Function
REQ-019 A request SHALL be accepted on a rising edge when req_valid=1 and req_ready=1; addr, size, unsigned, write and wdata SHALL be captured then.
REQ-020 FSM states SHALL be IDLE, RD, WR, RESP.
REQ-021 IDLE transitions: error -> RESP; load -> RD; word store -> WR; byte/half store -> RD (read-modify-write); no request -> IDLE.
REQ-022 Error conditions: req_size=11; half with addr[0]=1; word with addr[1:0]!=00; addr >= MEM_BYTES. An error SHALL issue no memory strobe.
REQ-023 RD: mem_read=1 for exactly one cycle; mem_dout SHALL be registered at the end of RD; next state SHALL be RESP for loads and WR for sub-word stores.
REQ-024 WR: mem_write=1 for exactly one cycle, with mem_din = the merged word; next state SHALL be RESP.
REQ-025 Merge: byte store SHALL replace lane addr[1:0] of the read word; half store SHALL replace bytes {addr[1],0}..{addr[1],1}; word store SHALL use req_wdata unchanged.
REQ-026 Load extraction: byte from lane addr[1:0], half from lane addr[1]; result SHALL be sign- or zero-extended to 32 bits per req_unsigned.
REQ-027 RESP: resp_valid=1 for one cycle, then IDLE; there is no response backpressure.
REQ-028 Latency from acceptance edge to resp_valid cycle SHALL be: error 1, load 2, word store 2, sub-word store 3.
REQ-029 mem_read and mem_write SHALL never both be 1; outside RD/WR both SHALL be 0, and outside WR mem_din SHALL be 0.
REQ-030 mem_addr SHALL hold {captured addr[31:2],2'b00} from acceptance until IDLE is re-entered, then 0.
REQ-031 req_valid while busy SHALL be ignored and not queued.

Reset
REQ-032 While reset=0: state SHALL be IDLE and every output SHALL be 0, including req_ready.
REQ-033 Reset asserted mid-operation SHALL abort immediately: no mem_write pulse afterwards and no resp_valid.
REQ-034 After reset deasserts, req_ready SHALL be 1 in the first cycle.

Verification
REQ-035 Word mem[0x10]=0x8899AABB; load byte addr 0x13 signed -> one RD cycle, resp_rdata=0xFFFFFF88 two cycles after accept; unsigned -> 0x00000088.
REQ-036 Word mem[0x20]=0x11223344; store half 0xBEEF at 0x22 -> RD, WR with mem_din=0xBEEF3344, resp at cycle 3; mem[0x20]=0xBEEF3344.
REQ-037 Store word 0xDEADBEEF at 0x04 -> no mem_read, WR mem_din=0xDEADBEEF, resp_err=0 at cycle 2.
REQ-038 Load word at 0x06, half at 0x01, size 11, and addr 0x10000 -> each gives resp_err=1 at cycle 1 and no memory strobe.
REQ-039 Reset pulled low during RD of a byte store -> no mem_write, no resp_valid, target word unchanged, req_ready=1 after release.
REQ-040 Back-to-back req_valid held high -> each request accepted only in IDLE; requests presented while busy are dropped.
